// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM states,
// NOP/HALT encodings and instruction field positions.
package fetch_stage_pkg;

   localparam int unsigned PC_W      = 16;
   localparam logic [15:0] NOP_INSTR = 16'h0800;
   localparam logic [4:0]  HALT_OPC  = 5'b00000;

   localparam int unsigned OPC_HI  = 15;
   localparam int unsigned OPC_LO  = 11;
   localparam int unsigned FUNC_HI = 1;
   localparam int unsigned FUNC_LO = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_FULL,
      S_DROP,
      S_HALTED
   } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry holding buffer for a fetched word that arrived while IF/ID
// was stalled.
module fetch_skid_buf #(
   parameter int unsigned PC_W      = fetch_stage_pkg::PC_W,
   parameter logic [15:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            drain,
   input  logic            clear,
   input  logic [15:0]     load_instr,
   input  logic [PC_W-1:0] load_pc2,
   output logic            valid,
   output logic [15:0]     instr,
   output logic [PC_W-1:0] pc2
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         instr <= NOP_INSTR;
         pc2   <= '0;
      end else if (clear || drain) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         instr <= load_instr;
         pc2   <= load_pc2;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single outstanding fetches
// and fills the IF/ID register, honouring stall, halt and EX redirects.
module fetch_stage #(
   parameter int unsigned      PC_W      = fetch_stage_pkg::PC_W,
   parameter logic [PC_W-1:0]  RESET_PC  = '0,
   parameter logic [15:0]      NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic [15:0]     imem_rdata,
   input  logic            imem_done,
   input  logic            halt,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   input  logic            stall_d,
   output logic            if_id_valid,
   output logic [15:0]     if_id_instr,
   output logic [PC_W-1:0] if_id_pc2,
   output logic [4:0]      I_op,
   output logic [1:0]      func,
   output logic            halted,
   output logic [PC_W-1:0] pc
);

   import fetch_stage_pkg::*;

   fetch_state_t    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d, pc_plus2;

   logic            ld_mem, ld_buf, flush;
   logic            buf_load, buf_drain, buf_clear;
   logic            buf_valid;
   logic [15:0]     buf_instr;
   logic [PC_W-1:0] buf_pc2;

   assign pc_plus2 = pc_q + PC_W'(2);

   fetch_skid_buf #(
      .PC_W      (PC_W),
      .NOP_INSTR (NOP_INSTR)
   ) u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (buf_load),
      .drain      (buf_drain),
      .clear      (buf_clear),
      .load_instr (imem_rdata),
      .load_pc2   (pc_plus2),
      .valid      (buf_valid),
      .instr      (buf_instr),
      .pc2        (buf_pc2)
   );

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ld_mem    = 1'b0;
      ld_buf    = 1'b0;
      flush     = 1'b0;
      buf_load  = 1'b0;
      buf_drain = 1'b0;
      buf_clear = 1'b0;

      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ:  state_d = S_WAIT;
         S_WAIT: begin
            if (imem_done) begin
               pc_d = pc_plus2;
               if (stall_d) begin
                  buf_load = 1'b1;
                  state_d  = S_FULL;
               end else begin
                  ld_mem  = 1'b1;
                  state_d = S_REQ;
               end
            end
         end
         S_FULL: begin
            if (!stall_d) begin
               ld_buf    = buf_valid;
               buf_drain = 1'b1;
               state_d   = S_REQ;
            end
         end
         S_DROP: begin
            if (imem_done) state_d = S_REQ;
         end
         S_HALTED: state_d = S_HALTED;
         default:  state_d = S_IDLE;
      endcase

      // Redirect overrides everything; halt overrides stall. Both cancel any
      // delivery or buffering decided above.
      if (redirect && state_q != S_IDLE && state_q != S_HALTED) begin
         pc_d      = redirect_pc;
         flush     = 1'b1;
         ld_mem    = 1'b0;
         ld_buf    = 1'b0;
         buf_load  = 1'b0;
         buf_drain = 1'b0;
         buf_clear = 1'b1;
         if (state_q == S_FULL || (imem_done && state_q != S_REQ))
            state_d = S_REQ;
         else
            state_d = S_DROP;
      end else if (halt && if_id_valid && state_q != S_HALTED) begin
         pc_d      = pc_q;
         flush     = 1'b1;
         ld_mem    = 1'b0;
         ld_buf    = 1'b0;
         buf_load  = 1'b0;
         buf_drain = 1'b0;
         buf_clear = 1'b1;
         state_d   = S_HALTED;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         if_id_valid <= 1'b0;
         if_id_instr <= NOP_INSTR;
         if_id_pc2   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         if (flush) begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
         end else if (ld_mem) begin
            if_id_valid <= 1'b1;
            if_id_instr <= imem_rdata;
            if_id_pc2   <= pc_plus2;
         end else if (ld_buf) begin
            if_id_valid <= 1'b1;
            if_id_instr <= buf_instr;
            if_id_pc2   <= buf_pc2;
         end else if (!stall_d) begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
         end
      end
   end

   assign imem_req  = (state_q == S_REQ);
   assign imem_addr = pc_q;
   assign halted    = (state_q == S_HALTED);
   assign pc        = pc_q;
   assign I_op      = if_id_instr[OPC_HI:OPC_LO];
   assign func      = if_id_instr[FUNC_HI:FUNC_LO];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a memory responder, a scoreboard monitor
// for requests and IF/ID deliveries, and a directed stimulus sequence.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata = 16'h0000;
   logic        imem_done = 1'b0;
   logic        halt = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic        stall_d = 1'b0;
   logic        if_id_valid;
   logic [15:0] if_id_instr;
   logic [15:0] if_id_pc2;
   logic [4:0]  I_op;
   logic [1:0]  func;
   logic        halted;
   logic [15:0] pc;

   int total = 0;
   int bad   = 0;

   logic [15:0] exp_req_q[$];
   logic [31:0] exp_del_q[$];

   int unsigned lat = 1;
   int unsigned stray_cnt = 0;

   always #5 clk = ~clk;

   fetch_stage #(
      .PC_W      (16),
      .RESET_PC  (16'h0000),
      .NOP_INSTR (16'h0800)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_done   (imem_done),
      .halt        (halt),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .stall_d     (stall_d),
      .if_id_valid (if_id_valid),
      .if_id_instr (if_id_instr),
      .if_id_pc2   (if_id_pc2),
      .I_op        (I_op),
      .func        (func),
      .halted      (halted),
      .pc          (pc)
   );

   function automatic logic [15:0] mem_rd(input logic [15:0] a);
      case (a)
         16'h0000: return 16'h4001;
         16'h0002: return 16'h5802;
         16'h0004: return 16'h2222;
         16'h0040: return 16'h6003;
         16'h0042: return 16'h3333;
         16'h0010: return 16'h0000;
         16'h0012: return 16'h4444;
         16'hFFFE: return 16'h7ABD;
         default:  return 16'h0800;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_req(input logic [15:0] a);
      int unsigned n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(imem_req === 1'b1 && imem_addr === a) && n < 60);
      total++;
      if (!(imem_req === 1'b1 && imem_addr === a)) begin
         bad++;
         $display("FAIL wait_req: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, a);
      end
   endtask

   // Memory model: answers each request after 'lat' cycles; stray strobes on demand.
   initial begin : responder
      int unsigned cnt;
      int unsigned seen;
      logic [15:0] a;
      cnt  = 0;
      seen = 0;
      a    = '0;
      forever begin
         @(negedge clk);
         imem_done = 1'b0;
         if (!rst_n) begin
            cnt = 0;
         end else if (imem_req) begin
            cnt = lat;
            a   = imem_addr;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               imem_done  = 1'b1;
               imem_rdata = mem_rd(a);
            end
         end else if (seen != stray_cnt) begin
            seen       = stray_cnt;
            imem_done  = 1'b1;
            imem_rdata = 16'h4001;
         end
      end
   end

   initial begin : monitor
      logic        pv;
      logic [15:0] ppc2;
      logic [15:0] ea;
      logic [31:0] ed;
      pv   = 1'b0;
      ppc2 = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pv = 1'b0;
         end else begin
            if (imem_req) begin
               if (exp_req_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL req_unexpected: got addr %h expected no request", imem_addr);
               end else begin
                  ea = exp_req_q.pop_front();
                  chk("req_addr", {16'h0, imem_addr}, {16'h0, ea});
               end
            end
            if (if_id_valid && (!pv || if_id_pc2 != ppc2)) begin
               if (exp_del_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL del_unexpected: got instr %h pc2 %h expected none", if_id_instr, if_id_pc2);
               end else begin
                  ed = exp_del_q.pop_front();
                  chk("delivery", {if_id_instr, if_id_pc2}, ed);
               end
            end
            pv   = if_id_valid;
            ppc2 = if_id_pc2;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      repeat (2) @(negedge clk);
      chk("rst_req",   {31'h0, imem_req},    32'h0);
      chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
      chk("rst_instr", {16'h0, if_id_instr}, 32'h0800);
      chk("rst_pc2",   {16'h0, if_id_pc2},   32'h0);
      chk("rst_pc",    {16'h0, pc},          32'h0);
      chk("rst_halt",  {31'h0, halted},      32'h0);

      exp_req_q.push_back(16'h0000);
      exp_req_q.push_back(16'h0002);
      exp_req_q.push_back(16'h0004);
      exp_del_q.push_back({16'h4001, 16'h0002});
      exp_del_q.push_back({16'h5802, 16'h0004});
      rst_n = 1'b1;

      wait_req(16'h0002);
      chk("first_instr", {16'h0, if_id_instr}, 32'h4001);
      chk("first_op",    {27'h0, I_op},        32'h08);
      chk("first_func",  {30'h0, func},        32'h1);
      chk("first_pc2",   {16'h0, if_id_pc2},   32'h0002);
      chk("first_pc",    {16'h0, pc},          32'h0002);

      // Stall across the response: word must park in the buffer.
      stall_d = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("full_no_req", {31'h0, imem_req},    32'h0);
         chk("full_hold",   {16'h0, if_id_instr}, 32'h4001);
      end
      chk("full_pc", {16'h0, pc}, 32'h0004);
      stall_d = 1'b0;
      lat     = 3;

      wait_req(16'h0004);
      chk("drain_instr", {16'h0, if_id_instr}, 32'h5802);
      chk("drain_pc2",   {16'h0, if_id_pc2},   32'h0004);

      @(negedge clk);
      redirect    = 1'b1;
      redirect_pc = 16'h0040;
      lat         = 1;
      exp_req_q.push_back(16'h0040);
      exp_req_q.push_back(16'h0042);
      exp_req_q.push_back(16'h0010);
      exp_req_q.push_back(16'h0012);
      exp_del_q.push_back({16'h6003, 16'h0042});
      exp_del_q.push_back({16'h0000, 16'h0012});
      @(negedge clk);
      redirect = 1'b0;
      chk("redir_valid", {31'h0, if_id_valid}, 32'h0);
      chk("redir_instr", {16'h0, if_id_instr}, 32'h0800);
      chk("redir_pc",    {16'h0, pc},          32'h0040);
      chk("redir_noreq", {31'h0, imem_req},    32'h0);
      repeat (2) @(negedge clk);
      chk("drop_valid",  {31'h0, if_id_valid}, 32'h0);

      wait_req(16'h0042);
      chk("tgt_instr", {16'h0, if_id_instr}, 32'h6003);
      chk("tgt_valid", {31'h0, if_id_valid}, 32'h1);
      redirect    = 1'b1;
      redirect_pc = 16'h0010;
      halt        = 1'b1;
      @(negedge clk);
      redirect = 1'b0;
      halt     = 1'b0;
      chk("rh_halted", {31'h0, halted}, 32'h0);
      chk("rh_pc",     {16'h0, pc},     32'h0010);

      wait_req(16'h0012);
      chk("halt_instr", {16'h0, if_id_instr}, 32'h0000);
      chk("halt_op",    {27'h0, I_op},        32'h00);
      halt    = 1'b1;
      stall_d = 1'b1;
      @(negedge clk);
      halt    = 1'b0;
      stall_d = 1'b0;
      chk("halted_set",   {31'h0, halted},      32'h1);
      chk("halted_valid", {31'h0, if_id_valid}, 32'h0);
      chk("halted_instr", {16'h0, if_id_instr}, 32'h0800);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("halted_noreq", {31'h0, imem_req}, 32'h0);
         chk("halted_stay",  {31'h0, halted},   32'h1);
         if (i == 5) stray_cnt++;
      end
      chk("stray_valid", {31'h0, if_id_valid}, 32'h0);
      chk("req_q_empty1", exp_req_q.size(), 32'h0);
      chk("del_q_empty1", exp_del_q.size(), 32'h0);

      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst2_halted", {31'h0, halted}, 32'h0);
      chk("rst2_pc",     {16'h0, pc},     32'h0);
      exp_req_q.push_back(16'h0000);
      exp_req_q.push_back(16'hFFFE);
      exp_req_q.push_back(16'h0000);
      exp_del_q.push_back({16'h7ABD, 16'h0000});
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      wait_req(16'h0000);
      redirect    = 1'b1;
      redirect_pc = 16'hFFFE;
      @(negedge clk);
      redirect = 1'b0;
      chk("wrap_tgt_pc", {16'h0, pc}, 32'hFFFE);
      wait_req(16'hFFFE);
      repeat (2) @(negedge clk);
      chk("wrap_pc",    {16'h0, pc},          32'h0000);
      chk("wrap_pc2",   {16'h0, if_id_pc2},   32'h0000);
      chk("wrap_instr", {16'h0, if_id_instr}, 32'h7ABD);

      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_valid", {31'h0, if_id_valid}, 32'h0);
      chk("async_instr", {16'h0, if_id_instr}, 32'h0800);
      chk("async_pc2",   {16'h0, if_id_pc2},   32'h0);
      chk("async_req",   {31'h0, imem_req},    32'h0);
      repeat (2) @(negedge clk);
      chk("req_q_empty2", exp_req_q.size(), 32'h0);
      chk("del_q_empty2", exp_del_q.size(), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
